// File: rtl/processor_pkg.sv
// Shared definitions for the instruction fetch/issue stage: opcode encodings,
// the fetch FSM state type and the opcode legality check.
package processor_pkg;

  localparam int INST_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  // True for the opcodes the downstream control unit can execute.
  function automatic logic op_supported(input logic [5:0] op);
    logic ok;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ: ok = 1'b1;
      default:                        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/processor_pc_next.sv
// Next-PC adder: sequential PC + 4, plus the word-scaled branch offset when the
// branch is taken. All arithmetic wraps modulo 2^ADDR_W.
module processor_pc_next
  import processor_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [INST_W-1:0] imm_sext,
  input  logic              take,
  output logic [ADDR_W-1:0] pc_next
);

  logic signed [ADDR_W-1:0] off_ext;
  logic        [ADDR_W-1:0] off_words;
  logic        [ADDR_W-1:0] seq_pc;

  // Sign-extend (or truncate) the immediate to the PC width, then scale to bytes.
  assign off_ext   = ADDR_W'($signed(imm_sext));
  assign off_words = off_ext <<< 2;
  assign seq_pc    = pc + ADDR_W'(4);
  assign pc_next   = take ? (seq_pc + off_words) : seq_pc;

endmodule

// File: rtl/processor_fetch_unit.sv
// Instruction fetch and issue stage. Holds the PC, fetches one word per
// instruction over a req/ack handshake, latches it into the instruction
// register, decodes its fields for the control unit/datapath and advances the
// PC once the issued instruction leaves (no stall).
module processor_fetch_unit
  import processor_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              branch,
  input  logic              zero,
  input  logic              stall,
  output logic              inst_valid,
  output logic [5:0]        ctl_op,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [5:0]        funct,
  output logic [INST_W-1:0] imm_sext,
  output logic [ADDR_W-1:0] pc,
  output logic              illegal_op,
  output logic [31:0]       instret
);

  fetch_state_t      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [INST_W-1:0] ir_q;
  logic [31:0]       instret_q;
  logic              illegal_q;
  logic              req_q;
  logic              valid_q;

  logic [ADDR_W-1:0] pc_d;
  logic              take;

  // Shift-amount field is not consumed by this stage or its neighbours.
  logic unused_shamt;
  assign unused_shamt = ^ir_q[10:6];

  // Branch outcome only matters when the FSM actually advances from ISSUE;
  // outside that case pc_d is ignored.
  assign take = branch & zero;

  processor_pc_next #(
    .ADDR_W(ADDR_W)
  ) u_pc_next (
    .pc      (pc_q),
    .imm_sext(imm_sext),
    .take    (take),
    .pc_next (pc_d)
  );

  // Fetch/issue FSM with registered handshake and valid outputs, so neither
  // depends combinationally on any input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      instret_q <= '0;
      illegal_q <= 1'b0;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
          valid_q <= 1'b0;
        end
        FETCH: begin
          if (imem_ack) begin
            ir_q  <= imem_rdata;
            req_q <= 1'b0;
            if (op_supported(imem_rdata[31:26])) begin
              state_q <= ISSUE;
              valid_q <= 1'b1;
            end else begin
              state_q   <= HALT;
              illegal_q <= 1'b1;
              valid_q   <= 1'b0;
            end
          end
        end
        ISSUE: begin
          if (!stall) begin
            pc_q      <= pc_d;
            instret_q <= instret_q + 32'd1;
            state_q   <= FETCH;
            req_q     <= 1'b1;
            valid_q   <= 1'b0;
          end
        end
        HALT: begin
          // Parked on the illegal word until reset.
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Field decode of the instruction register.
  assign ctl_op   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign inst_valid = valid_q;
  assign pc         = pc_q;
  assign illegal_op = illegal_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_processor_fetch_unit.sv
// Directed bench for processor_fetch_unit: reset, straight-line issue,
// branches, memory wait, stall, illegal opcode, PC wrap and reset mid-fetch.
module tb_processor_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, rst_b;
  logic        imem_ack, imem_ack_b;
  logic [31:0] imem_rdata, imem_rdata_b;
  logic        branch, zero, stall;

  logic        imem_req, inst_valid, illegal_op;
  logic [31:0] imem_addr, imm_sext, pc, instret;
  logic [5:0]  ctl_op, funct;
  logic [4:0]  rs, rt, rd;

  logic        b_req, b_valid, b_illegal;
  logic [31:0] b_addr, b_imm, b_pc, b_instret;
  logic [5:0]  b_op, b_funct;
  logic [4:0]  b_rs, b_rt, b_rd;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  processor_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .branch(branch), .zero(zero),
    .stall(stall), .inst_valid(inst_valid), .ctl_op(ctl_op), .rs(rs), .rt(rt),
    .rd(rd), .funct(funct), .imm_sext(imm_sext), .pc(pc),
    .illegal_op(illegal_op), .instret(instret)
  );

  processor_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst_b), .imem_req(b_req), .imem_addr(b_addr),
    .imem_ack(imem_ack_b), .imem_rdata(imem_rdata_b), .branch(1'b0), .zero(1'b0),
    .stall(1'b0), .inst_valid(b_valid), .ctl_op(b_op), .rs(b_rs), .rt(b_rt),
    .rd(b_rd), .funct(b_funct), .imm_sext(b_imm), .pc(b_pc),
    .illegal_op(b_illegal), .instret(b_instret)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // FETCH phase: hold ack low for 'waits' cycles, checking the request is
  // stable, then ack with 'word' in the next cycle.
  task automatic fetch(input string tag, input logic [31:0] word,
                       input logic [31:0] exp_addr, input int waits);
    for (int i = 0; i <= waits; i++) begin
      check_eq({tag, ".req"},  32'(imem_req), 32'd1);
      check_eq({tag, ".addr"}, imem_addr, exp_addr);
      if (i < waits) tick();
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
  endtask

  // ISSUE phase: check the issued opcode/PC, stall 'stalls' cycles, then
  // release with the given branch/zero.
  task automatic issue(input string tag, input logic [5:0] exp_op,
                       input logic [31:0] exp_pc, input int stalls,
                       input logic br, input logic zr);
    logic [31:0] ret0;
    ret0 = instret;
    check_eq({tag, ".valid"}, 32'(inst_valid), 32'd1);
    check_eq({tag, ".op"},    32'(ctl_op), 32'(exp_op));
    check_eq({tag, ".pc"},    pc, exp_pc);
    stall = 1'b1;
    for (int i = 0; i < stalls; i++) begin
      tick();
      check_eq({tag, ".stall_valid"},   32'(inst_valid), 32'd1);
      check_eq({tag, ".stall_op"},      32'(ctl_op), 32'(exp_op));
      check_eq({tag, ".stall_pc"},      pc, exp_pc);
      check_eq({tag, ".stall_instret"}, instret, ret0);
    end
    stall  = 1'b0;
    branch = br;
    zero   = zr;
    tick();
    branch = 1'b0;
    zero   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; rst_b = 1'b1;
    imem_ack = 1'b0; imem_rdata = '0; imem_ack_b = 1'b0; imem_rdata_b = '0;
    branch = 1'b0; zero = 1'b0; stall = 1'b0;

    // 1. Reset for two cycles, then one IDLE cycle, then FETCH of 0x0.
    tick(); tick();
    rst = 1'b0;
    check_eq("rst.req",     32'(imem_req), 32'd0);
    check_eq("rst.valid",   32'(inst_valid), 32'd0);
    check_eq("rst.pc",      pc, 32'h0);
    check_eq("rst.instret", instret, 32'd0);
    check_eq("rst.illegal", 32'(illegal_op), 32'd0);
    check_eq("rst.op",      32'(ctl_op), 32'd0);
    tick();

    // 2. Straight-line RTYPE / LW / SW.
    fetch("rtype", 32'h0022_1820, 32'h0, 0);
    check_eq("rtype.rs",    32'(rs), 32'd1);
    check_eq("rtype.rt",    32'(rt), 32'd2);
    check_eq("rtype.rd",    32'(rd), 32'd3);
    check_eq("rtype.funct", 32'(funct), 32'h20);
    check_eq("rtype.req",   32'(imem_req), 32'd0);
    issue("rtype", 6'b000000, 32'h0, 0, 1'b0, 1'b0);
    fetch("lw", 32'h8C43_FFF0, 32'h4, 0);
    check_eq("lw.imm", imm_sext, 32'hFFFF_FFF0);
    issue("lw", 6'b100011, 32'h4, 0, 1'b0, 1'b0);
    fetch("sw", 32'hAC45_0008, 32'h8, 0);
    check_eq("sw.imm", imm_sext, 32'h0000_0008);
    issue("sw", 6'b101011, 32'h8, 0, 1'b0, 1'b1);
    check_eq("line.instret", instret, 32'd3);

    // 3. Branches: 0xC -(-2 words)-> 0x8, -1 word -> 0x8, not taken -> 0xC,
    //    -2 words -> 0x8, +3 words -> 0x18.
    fetch("beq0", 32'h1022_FFFE, 32'hC, 0);
    issue("beq0", 6'b000100, 32'hC, 0, 1'b1, 1'b1);
    fetch("beq1", 32'h1022_FFFF, 32'h8, 0);
    check_eq("beq1.imm", imm_sext, 32'hFFFF_FFFF);
    issue("beq1", 6'b000100, 32'h8, 0, 1'b1, 1'b1);
    fetch("beq2", 32'h1022_FFFF, 32'h8, 0);
    issue("beq2", 6'b000100, 32'h8, 0, 1'b1, 1'b0);
    fetch("beq3", 32'h1022_FFFE, 32'hC, 0);
    issue("beq3", 6'b000100, 32'hC, 0, 1'b1, 1'b1);
    fetch("beq4", 32'h1022_0003, 32'h8, 0);
    issue("beq4", 6'b000100, 32'h8, 0, 1'b1, 1'b1);
    check_eq("br.addr",    imem_addr, 32'h18);
    check_eq("br.instret", instret, 32'd8);

    // 4. Three wait cycles in FETCH, two stall cycles in ISSUE.
    fetch("wait", 32'h0000_0020, 32'h18, 3);
    issue("stall", 6'b000000, 32'h18, 2, 1'b0, 1'b0);
    check_eq("stall.instret", instret, 32'd9);

    // 5. Illegal opcode: HALT with PC held, late acks ignored, then reset.
    fetch("ill", 32'hFC00_0000, 32'h1C, 0);
    check_eq("ill.flag",  32'(illegal_op), 32'd1);
    check_eq("ill.valid", 32'(inst_valid), 32'd0);
    for (int i = 0; i < 10; i++) begin
      check_eq("halt.req", 32'(imem_req), 32'd0);
      check_eq("halt.pc",  pc, 32'h1C);
      imem_ack   = (i == 4);
      imem_rdata = 32'h0000_0000;
      tick();
    end
    imem_ack = 1'b0;
    check_eq("halt.op",      32'(ctl_op), 32'h3F);
    check_eq("halt.instret", instret, 32'd9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("halt_rst.flag",    32'(illegal_op), 32'd0);
    check_eq("halt_rst.pc",      pc, 32'h0);
    check_eq("halt_rst.instret", instret, 32'd0);
    check_eq("halt_rst.op",      32'(ctl_op), 32'd0);
    tick();

    // 6a. Reset asserted while FETCH is acked: the word is dropped.
    check_eq("midrst.pre_req", 32'(imem_req), 32'd1);
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h8C43_FFF0;
    tick();
    rst = 1'b0;
    check_eq("midrst.req", 32'(imem_req), 32'd0);
    check_eq("midrst.op",  32'(ctl_op), 32'd0);
    check_eq("midrst.imm", imm_sext, 32'd0);
    tick();
    imem_ack = 1'b0;
    check_eq("midrst.late_op",  32'(ctl_op), 32'd0);
    check_eq("midrst.refetch",  32'(imem_req), 32'd1);
    check_eq("midrst.addr",     imem_addr, 32'h0);

    // 6b. PC wrap from 0xFFFFFFFC.
    rst_b = 1'b0;
    check_eq("wrap.rst_pc",  b_pc, 32'hFFFF_FFFC);
    check_eq("wrap.rst_req", 32'(b_req), 32'd0);
    tick();
    check_eq("wrap.req",  32'(b_req), 32'd1);
    check_eq("wrap.addr", b_addr, 32'hFFFF_FFFC);
    imem_ack_b = 1'b1; imem_rdata_b = 32'h0022_1820;
    tick();
    imem_ack_b = 1'b0;
    check_eq("wrap.valid", 32'(b_valid), 32'd1);
    tick();
    check_eq("wrap.next_req",  32'(b_req), 32'd1);
    check_eq("wrap.next_addr", b_addr, 32'h0);
    check_eq("wrap.instret",   b_instret, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/processor_fetch_unit.md
# processor_fetch_unit

Instruction fetch and issue stage that drives `processor_control_unit`. It holds the PC and fetches 32-bit words from instruction memory over a req/ack handshake. Each fetched word is latched in an instruction register, and the stage presents the opcode field on `ctl_op` and the register and immediate fields to the datapath. It then computes the next PC from the control unit's `branch` and the ALU's `zero`.

## Interface
Parameters:
- `ADDR_W`, 32, PC and instruction-memory address width (≥ 18)
- `RESET_PC`, 0, PC value loaded on reset (word aligned)

Ports (clock and reset first):
- `clk`  in  1  system clock; all state changes on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `imem_req`  out  1  fetch request; held high until `imem_ack`
- `imem_addr`  out  ADDR_W  fetch address; equals `pc`, stable while `imem_req`
- `imem_ack`  in  1  memory accepts the request; `imem_rdata` is valid in the same cycle
- `imem_rdata`  in  32  instruction word
- `branch`  in  1  from control unit
- `zero`  in  1  ALU zero flag
- `stall`  in  1  datapath hold; keeps the current instruction issued
- `inst_valid`  out  1  instruction register contents are being executed this cycle
- `ctl_op`  out  6  `ir[31:26]`, to the control unit
- `rs`, `rt`, `rd`  out  5 each  `ir[25:21]`, `ir[20:16]`, `ir[15:11]`
- `funct`  out  6  `ir[5:0]`
- `imm_sext`  out  32  `ir[15:0]` sign-extended
- `pc`  out  ADDR_W  address of the issued instruction
- `illegal_op`  out  1  sticky; an unsupported opcode was fetched
- `instret`  out  32  count of retired instructions

## Operation
- FSM states: IDLE, FETCH, ISSUE, HALT.
- **IDLE**:
  - Entered on reset.
  - Outputs `imem_req=0`, `inst_valid=0`.
  - Moves to FETCH unconditionally on the next cycle.
- **FETCH**:
  - Outputs `imem_req=1`, `imem_addr=pc`.
  - On `imem_ack`: latch `imem_rdata` into `ir`.
  - If opcode ∈ {000000 RTYPE, 100011 LW, 101011 SW, 000100 BEQ}, go to ISSUE; otherwise set `illegal_op`, go to HALT.
  - `stall` is ignored in FETCH.
- **ISSUE**:
  - Outputs `inst_valid=1`, `imem_req=0`.
  - If `stall=1`: stay in ISSUE; `ir` and `pc` hold.
  - If `stall=0`: update `pc`, increment `instret`, go to FETCH.
- **Next PC**, computed in the ISSUE cycle with `stall=0`:
  - If `branch & zero`: `pc + 4 + (imm_sext << 2)`.
  - Otherwise: `pc + 4`.
  - Arithmetic is modulo 2^ADDR_W; the sign-extended offset is truncated to ADDR_W, so the PC wraps silently.
- **HALT**:
  - Outputs `imem_req=0`, `inst_valid=0`.
  - `pc` holds the address of the illegal word.
  - Exits only via `rst`.
- `imem_ack` is ignored outside FETCH.
- `branch` and `zero` are sampled only in ISSUE with `stall=0`.
- `instret` wraps from 0xFFFF_FFFF to 0.

## Timing
- Reset values, applied in the cycle after `rst` is sampled high:
  - state = IDLE, `pc = RESET_PC`, `ir = 0` (RTYPE encoding), `instret = 0`
  - `illegal_op = 0`, `imem_req = 0`, `inst_valid = 0`
- `rst` overrides every other input in the same cycle.
- Reset during FETCH abandons the request: `imem_req` drops in the next cycle, and a late ack is ignored.
- Field outputs (`ctl_op`, `rs`, `rt`, `rd`, `funct`, `imm_sext`) decode `ir` combinationally.
- `imem_req`, `imem_addr` and `inst_valid` are decoded from state and registers only, with no combinational path from inputs.
- Throughput:
  - Best case: 2 cycles per instruction (FETCH with immediate ack, then ISSUE).
  - Each wait cycle in FETCH adds 1 cycle; each stall cycle in ISSUE adds 1 cycle.
- After `rst` deasserts: 1 IDLE cycle, then FETCH of `RESET_PC`.
- `illegal_op` asserts in the cycle after the ack of the offending word.

## Structure
- Shared package `processor_pkg`:
  - opcode constants `OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`
  - `fetch_state_t` enum
  - `INST_W = 32`
- Sub-module `processor_pc_next`: combinational next-PC adder.
  - Inputs: `pc`, `imm_sext`, `take`.
  - Output: `pc_next`.
- The FSM, `ir`, `pc` and `instret` registers live in the top module.

## Test plan
1. **Reset and first fetch**: `rst` high 2 cycles, then low.
   - Response: one IDLE cycle; `imem_req=1` with `imem_addr=0x0`; `instret=0`.
2. **Straight-line**: ack immediately with RTYPE, LW, SW words, `branch=0`.
   - Response: `pc` steps 0x0 → 0x4 → 0x8; `ctl_op` shows 000000, 100011, 101011 in successive ISSUE cycles; `instret=3` after 6 cycles.
3. **Branches**: BEQ with imm=0xFFFF at `pc=0x8`, `branch=1`, `zero=1`.
   - Response: next fetch at 0x8.
   - Same instruction with `zero=0`: next fetch at 0xC.
   - imm=0x0003: next fetch at 0x18.
4. **Memory wait and stall**:
   - Hold `imem_ack` low 3 cycles: `imem_req` and `imem_addr` stay stable throughout.
   - Hold `stall` high 2 cycles in ISSUE: `pc` and `ctl_op` hold; `instret` does not increment.
5. **Illegal opcode**: fetch word 0xFC000000.
   - Response: `illegal_op=1`; state HALT; `imem_req` stays 0 for 10 cycles; `pc` unchanged.
   - Then `rst`: `illegal_op=0`, `pc=RESET_PC`.
6. **Wrap and reset mid-fetch**:
   - `RESET_PC=0xFFFFFFFC`, RTYPE word: next fetch at 0x0.
   - Assert `rst` while `imem_req=1` and ack it in the same cycle: `ir` stays 0, state returns to IDLE.
